// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared encodings for the multi-cycle RV32I core
package core_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_t;

  localparam logic [1:0] TRAP_NONE           = 2'b00;
  localparam logic [1:0] TRAP_FETCH_MISALIGN = 2'b01;
  localparam logic [1:0] TRAP_LS_MISALIGN    = 2'b10;
  localparam logic [1:0] TRAP_INVALID        = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  // ALU op is {funct7[5], funct3} for register/immediate arithmetic
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] WB_IMM  = 2'b11;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - RV32I integer ALU
module alu
  import core_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  always_comb begin
    y = a + b;
    case (op)
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << b[4:0];
      ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'b0, a < b};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> b[4:0];
      ALU_SRA:  y = $signed(a) >>> b[4:0];
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = a + b;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - RV32I decode into datapath controls plus illegal-encoding detect
module control_unit
  import core_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic       reg_write,
  output logic       alu_src_imm,
  output logic       alu_a_pc,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_jal,
  output logic       is_jalr,
  output logic [3:0] alu_op,
  output logic [1:0] wb_sel,
  output logic       invalid_op
);

  always_comb begin
    reg_write   = 1'b0;
    alu_src_imm = 1'b0;
    alu_a_pc    = 1'b0;
    is_load     = 1'b0;
    is_store    = 1'b0;
    is_branch   = 1'b0;
    is_jal      = 1'b0;
    is_jalr     = 1'b0;
    alu_op      = ALU_ADD;
    wb_sel      = WB_ALU;
    invalid_op  = 1'b0;
    case (opcode)
      OP_LUI: begin
        reg_write = 1'b1;
        wb_sel    = WB_IMM;
      end
      OP_AUIPC: begin
        reg_write   = 1'b1;
        alu_a_pc    = 1'b1;
        alu_src_imm = 1'b1;
      end
      OP_JAL: begin
        reg_write = 1'b1;
        is_jal    = 1'b1;
        wb_sel    = WB_PC4;
      end
      OP_JALR: begin
        reg_write   = 1'b1;
        is_jalr     = 1'b1;
        alu_src_imm = 1'b1;
        wb_sel      = WB_PC4;
        invalid_op  = (funct3 != 3'b000);
      end
      OP_BRANCH: begin
        is_branch  = 1'b1;
        invalid_op = (funct3[2:1] == 2'b01);
      end
      OP_LOAD: begin
        reg_write   = 1'b1;
        is_load     = 1'b1;
        alu_src_imm = 1'b1;
        wb_sel      = WB_LOAD;
        case (funct3)
          F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: invalid_op = 1'b0;
          default:                             invalid_op = 1'b1;
        endcase
      end
      OP_STORE: begin
        is_store    = 1'b1;
        alu_src_imm = 1'b1;
        case (funct3)
          F3_SB, F3_SH, F3_SW: invalid_op = 1'b0;
          default:             invalid_op = 1'b1;
        endcase
      end
      OP_IMM: begin
        reg_write   = 1'b1;
        alu_src_imm = 1'b1;
        alu_op      = {1'b0, funct3};
        // shift-immediates carry funct7 in imm[11:5]; only SRAI may set bit 5
        if (funct3 == 3'b001) invalid_op = (funct7 != 7'h00);
        if (funct3 == 3'b101) begin
          alu_op     = {funct7[5], funct3};
          invalid_op = ((funct7 & 7'b1011111) != 7'h00);
        end
      end
      OP_REG: begin
        reg_write  = 1'b1;
        alu_op     = {funct7[5], funct3};
        invalid_op = !((funct7 == 7'h00) ||
                       ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      default: invalid_op = 1'b1;
    endcase
  end

endmodule

// File: rtl/core_multicycle_lsu_align.sv
// rtl/core_multicycle_lsu_align.sv - load/store lane steering, extension and misalign check
module lsu_align
  import core_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic        misaligned,
  output logic [3:0]  byte_en,
  output logic [31:0] store_wdata,
  output logic [31:0] load_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    case (addr_lo)
      2'd0:    ld_byte = load_word[7:0];
      2'd1:    ld_byte = load_word[15:8];
      2'd2:    ld_byte = load_word[23:16];
      default: ld_byte = load_word[31:24];
    endcase
    ld_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];
  end

  // funct3[2] selects zero extension, funct3[1:0] the access size
  always_comb begin
    misaligned  = 1'b0;
    byte_en     = 4'b0000;
    store_wdata = 32'h0;
    load_data   = 32'h0;
    case (funct3[1:0])
      SZ_BYTE: begin
        byte_en     = 4'b0001 << addr_lo;
        store_wdata = {4{store_data[7:0]}};
        load_data   = funct3[2] ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      end
      SZ_HALF: begin
        misaligned  = addr_lo[0];
        byte_en     = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_wdata = {2{store_data[15:0]}};
        load_data   = funct3[2] ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      end
      default: begin
        misaligned  = (addr_lo != 2'b00);
        byte_en     = 4'b1111;
        store_wdata = store_data;
        load_data   = load_word;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - immediate extraction for I/S/B/U/J formats
module imm_gen
  import core_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  always_comb begin
    imm = 32'h0;
    case (instr[6:0])
      OP_LOAD, OP_IMM, OP_JALR:
        imm = {{20{instr[31]}}, instr[31:20]};
      OP_STORE:
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH:
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {instr[31:12], 12'h0};
      OP_JAL:
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        imm = 32'h0;
    endcase
  end

endmodule

// File: rtl/regs_file.sv
// rtl/regs_file.sv - 32x32 register file, two async reads, x0 hard-wired to zero
module regs_file (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regs [32];

  always_ff @(posedge clk) begin
    if (we && (wa != 5'd0)) regs[wa] <= wd;
  end

  assign rd1 = (ra1 == 5'd0) ? 32'h0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'h0 : regs[ra2];

endmodule

// File: rtl/core_multicycle.sv
// rtl/core_multicycle.sv - multi-cycle RV32I core with valid/ready instruction and data ports
module core_multicycle
  import core_pkg::*;
#(
  parameter int          IMEM_ADDR_BITS = 10,
  parameter int          DMEM_ADDR_BITS = 10,
  parameter logic [31:0] RESET_PC       = 32'h0
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      imem_req,
  output logic [IMEM_ADDR_BITS-1:0] imem_addr,
  input  logic                      imem_ready,
  input  logic [31:0]               imem_rdata,
  output logic                      dmem_req,
  output logic [3:0]                dmem_we,
  output logic [DMEM_ADDR_BITS-1:0] dmem_addr,
  output logic [31:0]               dmem_wdata,
  input  logic                      dmem_ready,
  input  logic [31:0]               dmem_rdata,
  output logic                      retire,
  output logic                      halted,
  output logic [1:0]                trap_cause
);

  state_t      state, state_next;
  logic [31:0] pc, ir, rs1_q, rs2_q, imm_q, load_q;
  logic [1:0]  trap_cause_q;

  logic        reg_write, alu_src_imm, alu_a_pc, is_load, is_store;
  logic        is_branch, is_jal, is_jalr, invalid_op;
  logic [3:0]  alu_op;
  logic [1:0]  wb_sel;
  logic [31:0] rf_rd1, rf_rd2, imm, alu_a, alu_b, alu_y, wb_data;
  logic [31:0] pc_plus4, pc_target, next_pc;
  logic        br_taken, rf_we, ls_misaligned;
  logic [1:0]  exec_cause;
  logic [3:0]  ls_byte_en;
  logic [31:0] ls_wdata, ls_load_data;

  control_unit u_ctrl (
    .opcode      (ir[6:0]),
    .funct3      (ir[14:12]),
    .funct7      (ir[31:25]),
    .reg_write   (reg_write),
    .alu_src_imm (alu_src_imm),
    .alu_a_pc    (alu_a_pc),
    .is_load     (is_load),
    .is_store    (is_store),
    .is_branch   (is_branch),
    .is_jal      (is_jal),
    .is_jalr     (is_jalr),
    .alu_op      (alu_op),
    .wb_sel      (wb_sel),
    .invalid_op  (invalid_op)
  );

  imm_gen u_imm (
    .instr (ir),
    .imm   (imm)
  );

  regs_file u_regs (
    .clk (clk),
    .we  (rf_we),
    .ra1 (ir[19:15]),
    .ra2 (ir[24:20]),
    .wa  (ir[11:7]),
    .wd  (wb_data),
    .rd1 (rf_rd1),
    .rd2 (rf_rd2)
  );

  // Operands are registered, so the ALU result stays valid from EXEC through WB
  assign alu_a = alu_a_pc ? pc : rs1_q;
  assign alu_b = alu_src_imm ? imm_q : rs2_q;

  alu u_alu (
    .op (alu_op),
    .a  (alu_a),
    .b  (alu_b),
    .y  (alu_y)
  );

  lsu_align u_lsu (
    .addr_lo     (alu_y[1:0]),
    .funct3      (ir[14:12]),
    .store_data  (rs2_q),
    .load_word   (dmem_rdata),
    .misaligned  (ls_misaligned),
    .byte_en     (ls_byte_en),
    .store_wdata (ls_wdata),
    .load_data   (ls_load_data)
  );

  always_comb begin
    case (ir[14:12])
      BR_EQ:   br_taken = (rs1_q == rs2_q);
      BR_NE:   br_taken = (rs1_q != rs2_q);
      BR_LT:   br_taken = ($signed(rs1_q) < $signed(rs2_q));
      BR_GE:   br_taken = ($signed(rs1_q) >= $signed(rs2_q));
      BR_LTU:  br_taken = (rs1_q < rs2_q);
      BR_GEU:  br_taken = (rs1_q >= rs2_q);
      default: br_taken = 1'b0;
    endcase
  end

  assign pc_plus4  = pc + 32'd4;
  assign pc_target = pc + imm_q;

  always_comb begin
    next_pc = pc_plus4;
    if (is_jalr)                            next_pc = {alu_y[31:1], 1'b0};
    else if (is_jal || (is_branch && br_taken)) next_pc = pc_target;
  end

  // Invalid encoding outranks a bad target, which outranks a bad data address
  always_comb begin
    exec_cause = TRAP_NONE;
    if (invalid_op)                                    exec_cause = TRAP_INVALID;
    else if (next_pc[1:0] != 2'b00)                    exec_cause = TRAP_FETCH_MISALIGN;
    else if ((is_load || is_store) && ls_misaligned)   exec_cause = TRAP_LS_MISALIGN;
  end

  always_comb begin
    case (wb_sel)
      WB_LOAD: wb_data = load_q;
      WB_PC4:  wb_data = pc_plus4;
      WB_IMM:  wb_data = imm_q;
      default: wb_data = alu_y;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_BOOT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    retire     = 1'b0;
    rf_we      = 1'b0;
    case (state)
      ST_BOOT:   state_next = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) state_next = ST_DECODE;
      end
      ST_DECODE: state_next = ST_EXEC;
      ST_EXEC: begin
        if (exec_cause != TRAP_NONE)  state_next = ST_TRAP;
        else if (is_load || is_store) state_next = ST_MEM;
        else                          state_next = ST_WB;
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        if (dmem_ready) state_next = ST_WB;
      end
      ST_WB: begin
        retire     = 1'b1;
        rf_we      = reg_write;
        state_next = ST_FETCH;
      end
      ST_TRAP:   state_next = ST_TRAP;
      default:   state_next = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      ir           <= 32'h0;
      rs1_q        <= 32'h0;
      rs2_q        <= 32'h0;
      imm_q        <= 32'h0;
      load_q       <= 32'h0;
      trap_cause_q <= TRAP_NONE;
    end else begin
      if ((state == ST_FETCH) && imem_ready) ir <= imem_rdata;
      if (state == ST_DECODE) begin
        rs1_q <= rf_rd1;
        rs2_q <= rf_rd2;
        imm_q <= imm;
      end
      if ((state == ST_EXEC) && (exec_cause != TRAP_NONE)) trap_cause_q <= exec_cause;
      if ((state == ST_MEM) && dmem_ready) load_q <= ls_load_data;
      if (state == ST_WB) pc <= next_pc;
    end
  end

  assign imem_addr  = pc[IMEM_ADDR_BITS-1:0];
  assign dmem_addr  = dmem_req ? {alu_y[DMEM_ADDR_BITS-1:2], 2'b00} : '0;
  assign dmem_we    = (dmem_req && is_store) ? ls_byte_en : 4'b0000;
  assign dmem_wdata = (dmem_req && is_store) ? ls_wdata : 32'h0;
  assign halted     = (state == ST_TRAP);
  assign trap_cause = trap_cause_q;

endmodule
